// File: rtl/timer_pkg.sv
// Shared definitions for the 8-bit timer register responder.
//   - register indices within the 4-entry bank (TDR, TCR, TSR, TCNT)
//   - TSR flag bit positions
//   - bus FSM state type
//   - TSR next-state helper (set wins over write-0-to-clear)
package timer_pkg;

  typedef logic [1:0] reg_idx_t;

  localparam reg_idx_t TDR_ADDR  = 2'd0;
  localparam reg_idx_t TCR_ADDR  = 2'd1;
  localparam reg_idx_t TSR_ADDR  = 2'd2;
  localparam reg_idx_t TCNT_ADDR = 2'd3;

  localparam int unsigned TSR_OVF_BIT = 0;
  localparam int unsigned TSR_UDF_BIT = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  // A core pulse on the same edge as a clearing write leaves the flag set.
  function automatic logic [1:0] tsr_update(input logic [1:0] cur,
                                            input logic [1:0] set,
                                            input logic [1:0] clr);
    return set | (cur & ~clr);
  endfunction

endpackage

// File: rtl/timer_reg_bank.sv
// Timer register storage and read mux.
//   clk, rst_n     clock, asynchronous active-low reset
//   we             commit strobe for a validated write
//   widx, wdata    write register index and data
//   ridx           read register index (combinational read mux)
//   tcnt           live counter from the core, read-only
//   ovf_set/udf_set 1-cycle core pulses setting TSR flags
//   tdr, tcr       stored reload/control values driven to the core
//   rdata          read mux output
module timer_reg_bank
  import timer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  reg_idx_t   widx,
  input  logic [7:0] wdata,
  input  reg_idx_t   ridx,
  input  logic [7:0] tcnt,
  input  logic       ovf_set,
  input  logic       udf_set,
  output logic [7:0] tdr,
  output logic [7:0] tcr,
  output logic [7:0] rdata
);

  logic [7:0] tdr_q, tdr_d;
  logic [7:0] tcr_q, tcr_d;
  logic [1:0] tsr_q, tsr_d;
  logic [1:0] tsr_set, tsr_clr;

  always_comb begin
    tdr_d = tdr_q;
    tcr_d = tcr_q;
    if (we && (widx == TDR_ADDR)) tdr_d = wdata;
    if (we && (widx == TCR_ADDR)) tcr_d = wdata;
  end

  always_comb begin
    tsr_set = '0;
    tsr_set[TSR_OVF_BIT] = ovf_set;
    tsr_set[TSR_UDF_BIT] = udf_set;
    // Write-0-to-clear: only bits written as 0 are cleared.
    tsr_clr = (we && (widx == TSR_ADDR)) ? ~wdata[1:0] : 2'b00;
    tsr_d   = tsr_update(tsr_q, tsr_set, tsr_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tdr_q <= '0;
      tcr_q <= '0;
      tsr_q <= '0;
    end else begin
      tdr_q <= tdr_d;
      tcr_q <= tcr_d;
      tsr_q <= tsr_d;
    end
  end

  always_comb begin
    rdata = '0;
    unique case (ridx)
      TDR_ADDR:  rdata = tdr_q;
      TCR_ADDR:  rdata = tcr_q;
      TSR_ADDR:  rdata = {6'b0, tsr_q};
      TCNT_ADDR: rdata = tcnt;
      default:   rdata = '0;
    endcase
  end

  assign tdr = tdr_q;
  assign tcr = tcr_q;

endmodule

// File: rtl/timer_apb_responder.sv
// APB-style slave for the 8-bit timer register bank.
// Decodes CPU transfers, inserts WAIT_STATES wait cycles, flags illegal accesses
// with pslverr and holds TDR/TCR/TSR (via timer_reg_bank).
//   clk, rst_n                 clock, asynchronous active-low reset
//   psel, penable, pwrite      APB control
//   paddr, pwdata              address / write data
//   prdata, pready, pslverr    registered read data, completion, error
//   tdr, tcr                   register values to the timer core
//   tcnt                       live counter from core (read at 0x03)
//   ovf_set, udf_set           1-cycle flag pulses from core
// WAIT_STATES must be 0..7; the wait counter is 3 bits wide.
module timer_apb_responder
  import timer_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [7:0]        tdr,
  output logic [7:0]        tcr,
  input  logic [7:0]        tcnt,
  input  logic              ovf_set,
  input  logic              udf_set
);

  localparam logic [2:0] WaitLast = 3'(WAIT_STATES);

  apb_state_e        state_q, state_d;
  logic [2:0]        wait_cnt_q, wait_cnt_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;

  logic       addr_in_range;
  logic       addr_err;
  logic       ready;
  logic       ready_d;
  logic       commit;
  reg_idx_t   idx;
  logic [7:0] bank_rdata;

  // Only 0x00..0x03 exist; TCNT is read-only.
  assign idx           = paddr[1:0];
  assign addr_in_range = (paddr[ADDR_W-1:2] == '0);
  assign addr_err      = !addr_in_range || (pwrite && (idx == TCNT_ADDR));

  assign ready  = (state_q == ACCESS) && (wait_cnt_q == WaitLast);
  assign commit = ready && pwrite && !addr_err;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (psel && !penable) state_d = SETUP;
      end
      SETUP: begin
        if (!psel)        state_d = IDLE;
        else if (penable) state_d = ACCESS;
      end
      ACCESS: begin
        if (ready)      state_d = (psel && !penable) ? SETUP : IDLE;
        else if (!psel) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign wait_cnt_d = ((state_q == ACCESS) && (state_d == ACCESS)) ? wait_cnt_q + 3'd1 : 3'd0;

  // prdata is captured on the edge that enters the pready cycle, so it is
  // already stable while pready is high.
  assign ready_d = (state_d == ACCESS) && (wait_cnt_d == WaitLast);

  always_comb begin
    prdata_d = prdata_q;
    if (ready_d && !pwrite) prdata_d = addr_err ? '0 : DATA_W'(bank_rdata);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      prdata_q   <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      prdata_q   <= prdata_d;
    end
  end

  timer_reg_bank u_reg_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (commit),
    .widx    (idx),
    .wdata   (pwdata[7:0]),
    .ridx    (idx),
    .tcnt    (tcnt),
    .ovf_set (ovf_set),
    .udf_set (udf_set),
    .tdr     (tdr),
    .tcr     (tcr),
    .rdata   (bank_rdata)
  );

  assign prdata  = prdata_q;
  assign pready  = ready;
  assign pslverr = ready && addr_err;

endmodule

// File: tb/tb_timer_apb_responder.sv
// Directed bench for timer_apb_responder. Main DUT uses WAIT_STATES=1; two extra
// instances (0 and 3) share the bus to measure transfer length.
// Transfer length is counted from the first penable cycle to the pready cycle.
module tb_timer_apb_responder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [7:0] paddr = '0, pwdata = '0, tcnt = '0;
  logic       ovf_set = 1'b0, udf_set = 1'b0;

  logic [7:0] prdata, tdr, tcr;
  logic       pready, pslverr;
  logic [7:0] prdata0, tdr0, tcr0, prdata3, tdr3, tcr3;
  logic       pready0, pslverr0, pready3, pslverr3;

  int         n_cmp = 0;
  int         n_fail = 0;
  logic [7:0] tdr_at_ready;

  always #5 clk = ~clk;

  timer_apb_responder #(.WAIT_STATES(1), .ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .tdr(tdr), .tcr(tcr), .tcnt(tcnt), .ovf_set(ovf_set),
    .udf_set(udf_set)
  );

  timer_apb_responder #(.WAIT_STATES(0), .ADDR_W(8), .DATA_W(8)) dut_ws0 (
    .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata0), .pready(pready0),
    .pslverr(pslverr0), .tdr(tdr0), .tcr(tcr0), .tcnt(tcnt), .ovf_set(ovf_set),
    .udf_set(udf_set)
  );

  timer_apb_responder #(.WAIT_STATES(3), .ADDR_W(8), .DATA_W(8)) dut_ws3 (
    .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata3), .pready(pready3),
    .pslverr(pslverr3), .tdr(tdr3), .tcr(tcr3), .tcnt(tcnt), .ovf_set(ovf_set),
    .udf_set(udf_set)
  );

  // Bus master for the main DUT. Called and returns at posedge+1.
  // keep=1 leaves psel high so the next transfer follows with no idle cycle.
  task automatic xfer(input logic wr, input logic [7:0] addr, input logic [7:0] data,
                      input logic keep, input logic ovf_at_ready,
                      output logic [7:0] rd, output logic err, output int cyc);
    logic done;
    done = 1'b0; rd = '0; err = 1'b0; cyc = 0;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
    @(posedge clk); #1;
    penable = 1'b1;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (pready) begin
        done = 1'b1; rd = prdata; err = pslverr; tdr_at_ready = tdr;
        if (ovf_at_ready) ovf_set = 1'b1;
      end
    end
    n_cmp++;
    if (!done) begin
      n_fail++;
      $display("FAIL xfer_timeout addr=%h: pready seen=%b, required 1 within 20 cycles",
               addr, done);
    end
    @(posedge clk); #1;
    ovf_set = 1'b0;
    if (!keep) begin psel = 1'b0; penable = 1'b0; end
  endtask

  task automatic pulse(input logic ovf, input logic udf);
    ovf_set = ovf; udf_set = udf;
    @(posedge clk); #1;
    ovf_set = 1'b0; udf_set = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    logic [7:0] rd; logic err; int cyc;
    // Power-on reset state
    @(negedge clk);
    n_cmp++; if ({prdata, pready, pslverr} !== 10'h0) begin n_fail++;
      $display("FAIL por_outputs: got %h required 000", {prdata, pready, pslverr}); end
    n_cmp++; if ({tdr, tcr} !== 16'h0) begin n_fail++;
      $display("FAIL por_regs: got %h required 0000", {tdr, tcr}); end
    @(posedge clk); #1; rst_n = 1'b1;
    idle(1);
    xfer(1'b1, 8'h00, 8'h5A, 1'b0, 1'b0, rd, err, cyc);
    xfer(1'b1, 8'h01, 8'hA5, 1'b0, 1'b0, rd, err, cyc);
    xfer(1'b1, 8'h02, 8'hA5, 1'b0, 1'b0, rd, err, cyc);
    pulse(1'b1, 1'b0);
    xfer(1'b0, 8'h02, 8'h00, 1'b0, 1'b0, rd, err, cyc);
    n_cmp++; if (rd !== 8'h01) begin n_fail++;
      $display("FAIL pre_reset_tsr: got %h required 01", rd); end
    n_cmp++; if (tcr !== 8'hA5) begin n_fail++;
      $display("FAIL pre_reset_tcr: got %h required a5", tcr); end
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++; if ({tdr, tcr, prdata} !== 24'h0) begin n_fail++;
      $display("FAIL reset_regs: got %h required 000000", {tdr, tcr, prdata}); end
    @(posedge clk); #1; rst_n = 1'b1;
    idle(1);
    for (int a = 0; a < 3; a++) begin
      xfer(1'b0, 8'(a), 8'h00, 1'b0, 1'b0, rd, err, cyc);
      n_cmp++; if (rd !== 8'h00) begin n_fail++;
        $display("FAIL reset_read_%0d: got %h required 00", a, rd); end
    end
  endtask

  task automatic test_rw();
    logic [7:0] rd; logic err; int cyc;
    xfer(1'b1, 8'h00, 8'h3C, 1'b0, 1'b0, rd, err, cyc);
    n_cmp++; if (cyc !== 3) begin n_fail++;
      $display("FAIL rw_latency: got %0d cycles required 3", cyc); end
    n_cmp++; if (tdr_at_ready !== 8'h00) begin n_fail++;
      $display("FAIL rw_tdr_before_edge: got %h required 00", tdr_at_ready); end
    n_cmp++; if (tdr !== 8'h3C) begin n_fail++;
      $display("FAIL rw_tdr_after_edge: got %h required 3c", tdr); end
    n_cmp++; if (err !== 1'b0) begin n_fail++;
      $display("FAIL rw_write_err: got %b required 0", err); end
    xfer(1'b1, 8'h01, 8'hC3, 1'b0, 1'b0, rd, err, cyc);
    n_cmp++; if (tcr !== 8'hC3) begin n_fail++;
      $display("FAIL rw_tcr: got %h required c3", tcr); end
    xfer(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, rd, err, cyc);
    n_cmp++; if (rd !== 8'h3C) begin n_fail++;
      $display("FAIL rw_read_tdr: got %h required 3c", rd); end
    xfer(1'b0, 8'h01, 8'h00, 1'b0, 1'b0, rd, err, cyc);
    n_cmp++; if ({rd, err} !== {8'hC3, 1'b0}) begin n_fail++;
      $display("FAIL rw_read_tcr: got %h/%b required c3/0", rd, err); end
    n_cmp++; if (cyc !== 3) begin n_fail++;
      $display("FAIL rw_read_latency: got %0d cycles required 3", cyc); end
  endtask

  task automatic test_tsr();
    logic [7:0] rd; logic err; int cyc;
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    xfer(1'b0, 8'h02, 8'h00, 1'b0, 1'b0, rd, err, cyc);
    n_cmp++; if (rd !== 8'h03) begin n_fail++;
      $display("FAIL tsr_both_set: got %h required 03", rd); end
    xfer(1'b1, 8'h02, 8'hFE, 1'b0, 1'b0, rd, err, cyc);
    xfer(1'b0, 8'h02, 8'h00, 1'b0, 1'b0, rd, err, cyc);
    n_cmp++; if (rd !== 8'h02) begin n_fail++;
      $display("FAIL tsr_w0c_ovf: got %h required 02", rd); end
    // Clear-all write coinciding with an overflow pulse
    xfer(1'b1, 8'h02, 8'h00, 1'b0, 1'b1, rd, err, cyc);
    xfer(1'b0, 8'h02, 8'h00, 1'b0, 1'b0, rd, err, cyc);
    n_cmp++; if (rd !== 8'h01) begin n_fail++;
      $display("FAIL tsr_set_wins: got %h required 01", rd); end
  endtask

  task automatic test_errors();
    logic [7:0] rd; logic err; int cyc;
    tcnt = 8'h7E;
    xfer(1'b1, 8'h03, 8'h55, 1'b0, 1'b0, rd, err, cyc);
    n_cmp++; if ({err, 4'(cyc)} !== {1'b1, 4'd3}) begin n_fail++;
      $display("FAIL err_write_tcnt: got err=%b cyc=%0d required 1/3", err, cyc); end
    xfer(1'b1, 8'h07, 8'h55, 1'b0, 1'b0, rd, err, cyc);
    n_cmp++; if (err !== 1'b1) begin n_fail++;
      $display("FAIL err_write_07: got %b required 1", err); end
    n_cmp++; if ({tdr, tcr} !== 16'h3CC3) begin n_fail++;
      $display("FAIL err_no_change: got %h required 3cc3", {tdr, tcr}); end
    xfer(1'b0, 8'h09, 8'h00, 1'b0, 1'b0, rd, err, cyc);
    n_cmp++; if ({rd, err} !== {8'h00, 1'b1}) begin n_fail++;
      $display("FAIL err_read_09: got %h/%b required 00/1", rd, err); end
    xfer(1'b0, 8'h03, 8'h00, 1'b0, 1'b0, rd, err, cyc);
    n_cmp++; if ({rd, err} !== {8'h7E, 1'b0}) begin n_fail++;
      $display("FAIL read_tcnt: got %h/%b required 7e/0", rd, err); end
    xfer(1'b1, 8'h00, 8'h3C, 1'b0, 1'b0, rd, err, cyc);
    n_cmp++; if (rd !== 8'h7E) begin n_fail++;
      $display("FAIL write_keeps_prdata: got %h required 7e", rd); end
  endtask

  task automatic test_protocol();
    logic [7:0] rd; logic err; int cyc; logic seen;
    // Abort a write by dropping psel in the first ACCESS cycle
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'h11;
    @(posedge clk); #1; penable = 1'b1;
    @(posedge clk); #1; psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    n_cmp++; if (pready !== 1'b0) begin n_fail++;
      $display("FAIL abort_no_ready: got %b required 0", pready); end
    idle(2);
    n_cmp++; if (tdr !== 8'h3C) begin n_fail++;
      $display("FAIL abort_tdr: got %h required 3c", tdr); end
    // penable without a setup phase
    seen = 1'b0;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 8'h00;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); if (pready) seen = 1'b1;
    end
    @(posedge clk); #1; psel = 1'b0; penable = 1'b0;
    n_cmp++; if (seen !== 1'b0) begin n_fail++;
      $display("FAIL no_setup_ready: got %b required 0", seen); end
    idle(1);
    // Back-to-back write then read with psel held high
    xfer(1'b1, 8'h00, 8'h5A, 1'b1, 1'b0, rd, err, cyc);
    n_cmp++; if (cyc !== 3) begin n_fail++;
      $display("FAIL b2b_write_latency: got %0d required 3", cyc); end
    xfer(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, rd, err, cyc);
    n_cmp++; if ({rd, 4'(cyc)} !== {8'h5A, 4'd3}) begin n_fail++;
      $display("FAIL b2b_read: got %h/%0d required 5a/3", rd, cyc); end
  endtask

  task automatic test_param_sweep();
    int c0, c1, c3, cnt;
    idle(3);
    c0 = 0; c1 = 0; c3 = 0; cnt = 0;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h01;
    @(posedge clk); #1; penable = 1'b1;
    while (c3 == 0 && cnt < 20) begin
      @(negedge clk);
      cnt++;
      if (pready0 && c0 == 0) c0 = cnt;
      if (pready && c1 == 0) c1 = cnt;
      if (pready3 && c3 == 0) c3 = cnt;
    end
    @(posedge clk); #1; psel = 1'b0; penable = 1'b0;
    n_cmp++; if (c0 !== 2) begin n_fail++;
      $display("FAIL sweep_ws0: got %0d cycles required 2", c0); end
    n_cmp++; if (c1 !== 3) begin n_fail++;
      $display("FAIL sweep_ws1: got %0d cycles required 3", c1); end
    n_cmp++; if (c3 !== 5) begin n_fail++;
      $display("FAIL sweep_ws3: got %0d cycles required 5", c3); end
    idle(2);
  endtask

  initial begin
    test_reset();
    test_rw();
    test_tsr();
    test_errors();
    test_protocol();
    test_param_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
